// File: rtl/multitap_effects.sv
// multitap_effects: per-sample effects engine (N-tap delay/chorus, overdrive,
// saturation). Each accepted ADC sample has its DC offset removed, is written
// to the delay RAM, then every enabled tap is read back, attenuated and summed
// into the dry value before the result is shaped and sent to the DAC.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   sample_valid        one-cycle strobe qualifying sample_in
//   sample_in, offset   unsigned ADC sample and DC offset
//   tap_en/delay/shift  per-tap enable, delay in samples, attenuation shift
//   drive_en/shift      overdrive enable and gain (left shift)
//   sat_level           magnitude ceiling while overdrive is on
//   ram_addr/we/wdata   delay RAM port, data as {sign, magnitude}
//   ram_rdata           RAM read data, valid one cycle after ram_addr
//   out_valid           one-cycle strobe, out_sample updated
//   out_sample          {sign, magnitude} to DAC, held between strobes
//   busy                high whenever a sample is in flight
//   overrun             sticky: a sample arrived while busy and was dropped
module multitap_effects #(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned NUM_TAPS = 4,
    parameter int unsigned ACC_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic [DATA_W-1:0]          sample_in,
    input  logic [DATA_W-1:0]          offset,
    input  logic [NUM_TAPS-1:0]        tap_en,
    input  logic [NUM_TAPS*ADDR_W-1:0] tap_delay,
    input  logic [NUM_TAPS*2-1:0]      tap_shift,
    input  logic                       drive_en,
    input  logic [2:0]                 drive_shift,
    input  logic [DATA_W-1:0]          sat_level,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic                       ram_we,
    output logic [DATA_W:0]            ram_wdata,
    input  logic [DATA_W:0]            ram_rdata,
    output logic                       out_valid,
    output logic [DATA_W:0]            out_sample,
    output logic                       busy,
    output logic                       overrun
);

    localparam int unsigned IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [DATA_W-1:0] MAG_MAX     = '1;
    localparam logic [ACC_W-1:0]  MAG_MAX_ACC = ACC_W'(MAG_MAX);
    localparam logic [ACC_W-1:0]  DRIVE_KNEE  = ACC_W'(31);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] SHAPE = 3'd4;

    logic [2:0]                 state_q, state_d;
    logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]          base_q, base_d;
    logic [NUM_TAPS-1:0]        mask_q, mask_d;
    logic [NUM_TAPS*ADDR_W-1:0] delay_q, delay_d;
    logic [NUM_TAPS*2-1:0]      shift_q, shift_d;
    logic                       drive_en_q, drive_en_d;
    logic [2:0]                 drive_shift_q, drive_shift_d;
    logic [DATA_W-1:0]          sat_q, sat_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       addr_tap_q, addr_tap_d;
    logic [1:0]                 addr_shift_q, addr_shift_d;
    logic                       data_tap_q, data_tap_d;
    logic [1:0]                 data_shift_q, data_shift_d;
    logic [ADDR_W-1:0]          ram_addr_d;
    logic                       ram_we_d;
    logic [DATA_W:0]            ram_wdata_d;
    logic                       out_valid_d;
    logic [DATA_W:0]            out_sample_d;
    logic                       busy_d;
    logic                       overrun_d;

    // Lowest-index enabled tap still waiting to be issued
    logic [IDX_W-1:0] first_idx;
    logic             have_tap;

    always_comb begin
        first_idx = '0;
        have_tap  = 1'b0;
        for (int i = NUM_TAPS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_idx = IDX_W'(i);
                have_tap  = 1'b1;
            end
        end
    end

    logic signed [ACC_W-1:0] dry;
    logic [ACC_W-1:0]        dry_abs;
    logic signed [ACC_W-1:0] tap_mag;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    acc_neg;
    logic [ACC_W-1:0]        acc_abs;
    logic [ACC_W-1:0]        shaped;
    logic [ACC_W-1:0]        ceiling;
    logic [ACC_W-1:0]        mag;
    logic                    issue;

    // Next-state and datapath
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        base_d        = base_q;
        mask_d        = mask_q;
        delay_d       = delay_q;
        shift_d       = shift_q;
        drive_en_d    = drive_en_q;
        drive_shift_d = drive_shift_q;
        sat_d         = sat_q;
        addr_tap_d    = 1'b0;
        addr_shift_d  = addr_shift_q;
        data_tap_d    = addr_tap_q;
        data_shift_d  = addr_shift_q;
        ram_addr_d    = ram_addr;
        ram_we_d      = 1'b0;
        ram_wdata_d   = ram_wdata;
        out_valid_d   = 1'b0;
        out_sample_d  = out_sample;
        overrun_d     = overrun | (sample_valid && (state_q != IDLE));
        issue         = 1'b0;

        dry     = $signed(ACC_W'(sample_in)) - $signed(ACC_W'(offset));
        dry_abs = dry[ACC_W-1] ? ACC_W'(-dry) : ACC_W'(dry);

        // Accumulate the tap whose read data is on ram_rdata this cycle
        tap_mag = $signed(ACC_W'(ram_rdata[DATA_W-1:0] >> data_shift_q));
        if (data_tap_q) begin
            acc_sum = ram_rdata[DATA_W] ? (acc_q - tap_mag) : (acc_q + tap_mag);
        end else begin
            acc_sum = acc_q;
        end
        acc_d = acc_sum;

        // Shaping works on the final sum so out_sample is ready in SHAPE
        acc_neg = acc_sum[ACC_W-1];
        acc_abs = acc_neg ? ACC_W'(-acc_sum) : ACC_W'(acc_sum);
        if (drive_en_q && (acc_abs > DRIVE_KNEE)) begin
            shaped  = acc_abs << drive_shift_q;
            ceiling = ACC_W'(sat_q);
        end else begin
            shaped  = acc_abs;
            ceiling = MAG_MAX_ACC;
        end
        mag = (shaped > ceiling) ? ceiling : shaped;

        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    state_d       = WRITE;
                    base_d        = wr_ptr_q;
                    mask_d        = tap_en;
                    delay_d       = tap_delay;
                    shift_d       = tap_shift;
                    drive_en_d    = drive_en;
                    drive_shift_d = drive_shift;
                    sat_d         = sat_level;
                    acc_d         = dry;
                    ram_we_d      = 1'b1;
                    ram_addr_d    = wr_ptr_q;
                    ram_wdata_d   = {dry[ACC_W-1],
                                     (dry_abs > MAG_MAX_ACC) ? MAG_MAX : dry_abs[DATA_W-1:0]};
                end
            end
            WRITE: begin
                wr_ptr_d = base_q + ADDR_W'(1);
                issue    = have_tap;
                state_d  = have_tap ? READ : DRAIN;
            end
            READ: begin
                issue   = have_tap;
                state_d = have_tap ? READ : DRAIN;
            end
            DRAIN: begin
                out_sample_d = {acc_neg && (mag[DATA_W-1:0] != '0), mag[DATA_W-1:0]};
                out_valid_d  = 1'b1;
                state_d      = SHAPE;
            end
            SHAPE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            ram_addr_d        = base_q - delay_q[first_idx*ADDR_W +: ADDR_W];
            addr_tap_d        = 1'b1;
            addr_shift_d      = shift_q[first_idx*2 +: 2];
            mask_d[first_idx] = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            base_q        <= '0;
            mask_q        <= '0;
            delay_q       <= '0;
            shift_q       <= '0;
            drive_en_q    <= 1'b0;
            drive_shift_q <= '0;
            sat_q         <= '0;
            acc_q         <= '0;
            addr_tap_q    <= 1'b0;
            addr_shift_q  <= '0;
            data_tap_q    <= 1'b0;
            data_shift_q  <= '0;
            ram_addr      <= '0;
            ram_we        <= 1'b0;
            ram_wdata     <= '0;
            out_valid     <= 1'b0;
            out_sample    <= '0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            base_q        <= base_d;
            mask_q        <= mask_d;
            delay_q       <= delay_d;
            shift_q       <= shift_d;
            drive_en_q    <= drive_en_d;
            drive_shift_q <= drive_shift_d;
            sat_q         <= sat_d;
            acc_q         <= acc_d;
            addr_tap_q    <= addr_tap_d;
            addr_shift_q  <= addr_shift_d;
            data_tap_q    <= data_tap_d;
            data_shift_q  <= data_shift_d;
            ram_addr      <= ram_addr_d;
            ram_we        <= ram_we_d;
            ram_wdata     <= ram_wdata_d;
            out_valid     <= out_valid_d;
            out_sample    <= out_sample_d;
            busy          <= busy_d;
            overrun       <= overrun_d;
        end
    end

endmodule

// File: tb/tb_multitap_effects.sv
// tb_multitap_effects: self-checking bench for multitap_effects with a delay
// RAM model, a table of directed vectors, hand-written multi-cycle sequences
// and randomized samples checked against a sample-level reference model.
module tb_multitap_effects;

    localparam int unsigned DATA_W   = 10;
    localparam int unsigned ADDR_W   = 13;
    localparam int unsigned NUM_TAPS = 4;
    localparam int unsigned ACC_W    = 16;
    localparam int DEPTH = 1 << ADDR_W;

    logic                       clk;
    logic                       reset;
    logic                       sample_valid;
    logic [DATA_W-1:0]          sample_in;
    logic [DATA_W-1:0]          offset;
    logic [NUM_TAPS-1:0]        tap_en;
    logic [NUM_TAPS*ADDR_W-1:0] tap_delay;
    logic [NUM_TAPS*2-1:0]      tap_shift;
    logic                       drive_en;
    logic [2:0]                 drive_shift;
    logic [DATA_W-1:0]          sat_level;
    logic [ADDR_W-1:0]          ram_addr;
    logic                       ram_we;
    logic [DATA_W:0]            ram_wdata;
    logic [DATA_W:0]            ram_rdata;
    logic                       out_valid;
    logic [DATA_W:0]            out_sample;
    logic                       busy;
    logic                       overrun;

    multitap_effects #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_TAPS(NUM_TAPS), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid),
        .sample_in(sample_in), .offset(offset), .tap_en(tap_en),
        .tap_delay(tap_delay), .tap_shift(tap_shift), .drive_en(drive_en),
        .drive_shift(drive_shift), .sat_level(sat_level),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .out_valid(out_valid), .out_sample(out_sample),
        .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous delay RAM with a side port for preloading
    logic [DATA_W:0]   mem [0:DEPTH-1] = '{default: '0};
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W:0]   pre_data = '0;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
        ram_rdata <= mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Reference model: history of written samples plus sample-level arithmetic
    logic [DATA_W:0] ref_mem [0:DEPTH-1] = '{default: '0};
    int ref_ptr = 0;
    int e_out, e_t, e_waddr, e_wdata;
    int e_raddr [NUM_TAPS];

    task automatic ref_process(input int si, input int off, input logic [3:0] en,
                               input logic [51:0] dl, input logic [7:0] sh,
                               input logic de, input int ds, input int sat);
        int dry, acc, a, ceil_v, m, d, s, v, k, tm;
        dry = si - off;
        acc = dry;
        a = (dry < 0) ? -dry : dry;
        if (a > 1023) a = 1023;
        e_wdata = ((dry < 0) ? 1024 : 0) + a;
        e_waddr = ref_ptr;
        ref_mem[ref_ptr] = 11'(e_wdata);
        k = 0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (en[i]) begin
                d = int'(dl[i*ADDR_W +: ADDR_W]);
                s = int'(sh[i*2 +: 2]);
                e_raddr[k] = (ref_ptr - d) & (DEPTH - 1);
                v = int'(ref_mem[e_raddr[k]]);
                tm = (v & 1023) >> s;
                if (v >= 1024) acc = acc - tm;
                else acc = acc + tm;
                k++;
            end
        end
        e_t = k;
        a = (acc < 0) ? -acc : acc;
        if (de && a > 31) begin
            a = (a << ds) & ((1 << ACC_W) - 1);
            ceil_v = sat;
        end else begin
            ceil_v = 1023;
        end
        m = (a > ceil_v) ? ceil_v : a;
        e_out = ((acc < 0 && m != 0) ? 1024 : 0) + m;
        ref_ptr = (ref_ptr + 1) & (DEPTH - 1);
    endtask

    // Observations from one sample
    int g_out, g_lat, n_we, we_cycle, g_waddr, g_wdata, busy_cnt, busy_after, ov_after;
    int rd_log [0:63];

    task automatic run_sample(input logic [9:0] si, input logic [9:0] off,
                              input logic [3:0] en, input logic [51:0] dl,
                              input logic [7:0] sh, input logic de,
                              input logic [2:0] ds, input logic [9:0] sat);
        @(negedge clk);
        sample_in = si; offset = off; tap_en = en; tap_delay = dl;
        tap_shift = sh; drive_en = de; drive_shift = ds; sat_level = sat;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        // Config is latched at accept; garbage afterwards must not matter
        sample_in = 10'($urandom); offset = 10'($urandom); tap_en = 4'($urandom);
        tap_delay = 52'({$urandom, $urandom}); tap_shift = 8'($urandom);
        drive_en = 1'($urandom); drive_shift = 3'($urandom); sat_level = 10'($urandom);
        g_lat = -1; g_out = -1; n_we = 0; we_cycle = -1; busy_cnt = 0;
        g_waddr = -1; g_wdata = -1;
        for (int k = 1; k < 40; k++) begin
            rd_log[k] = int'(ram_addr);
            if (ram_we) begin
                n_we++; we_cycle = k;
                g_waddr = int'(ram_addr); g_wdata = int'(ram_wdata);
            end
            if (busy) busy_cnt++;
            if (out_valid) begin
                g_out = int'(out_sample); g_lat = k;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        busy_after = int'(busy);
        ov_after = int'(out_valid);
    endtask

    task automatic compare_all(input string name);
        check({name, " out_sample"}, g_out, e_out);
        check({name, " latency"}, g_lat, e_t + 3);
        check({name, " ram_we count"}, n_we, 1);
        check({name, " ram_we cycle"}, we_cycle, 1);
        check({name, " write addr"}, g_waddr, e_waddr);
        check({name, " write data"}, g_wdata, e_wdata);
        check({name, " busy cycles"}, busy_cnt, e_t + 3);
        check({name, " busy after"}, busy_after, 0);
        check({name, " out_valid after"}, ov_after, 0);
        for (int j = 0; j < e_t; j++)
            check($sformatf("%s read addr %0d", name, j), rd_log[2 + j], e_raddr[j]);
    endtask

    task automatic apply(input string name, input logic [9:0] si, input logic [9:0] off,
                         input logic [3:0] en, input logic [51:0] dl, input logic [7:0] sh,
                         input logic de, input logic [2:0] ds, input logic [9:0] sat);
        ref_process(int'(si), int'(off), en, dl, sh, de, int'(ds), int'(sat));
        run_sample(si, off, en, dl, sh, de, ds, sat);
        compare_all(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; sample_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ref_ptr = 0;
    endtask

    typedef struct {
        logic        rst;
        logic [9:0]  si;
        logic [9:0]  off;
        logic [3:0]  en;
        logic [51:0] dl;
        logic [7:0]  sh;
        logic        de;
        logic [2:0]  ds;
        logic [9:0]  sat;
        int          exp_out;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [9:0] si, input logic [9:0] off,
                                input logic [3:0] en, input logic [51:0] dl,
                                input logic [7:0] sh, input logic de, input logic [2:0] ds,
                                input logic [9:0] sat, input int exp_out);
        vec_t v;
        v.rst = rst; v.si = si; v.off = off; v.en = en; v.dl = dl; v.sh = sh;
        v.de = de; v.ds = ds; v.sat = sat; v.exp_out = exp_out;
        return v;
    endfunction

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    initial begin
        logic [51:0] dl;
        logic [51:0] dl_abort;
        int ovc, ov_seen, we_seen;

        reset = 1'b1; sample_valid = 1'b0; sample_in = '0; offset = '0;
        tap_en = '0; tap_delay = '0; tap_shift = '0; drive_en = 1'b0;
        drive_shift = '0; sat_level = '0;

        // Directed vectors: {reset first, inputs..., expected out_sample}
        vecs[0] = mk(1'b1, 10'd700, 10'd512, 4'h0, 52'd0, 8'd0, 1'b0, 3'd0, 10'd0, 188);
        vecs[1] = mk(1'b0, 10'd400, 10'd512, 4'h0, 52'd0, 8'd0, 1'b0, 3'd0, 10'd0, 1024 + 112);
        vecs[2] = mk(1'b1, 10'd100, 10'd0,   4'h1, 52'd2, 8'd0, 1'b0, 3'd0, 10'd0, 100);
        vecs[3] = mk(1'b0, 10'd0,   10'd0,   4'h1, 52'd2, 8'd0, 1'b0, 3'd0, 10'd0, 0);
        vecs[4] = mk(1'b0, 10'd0,   10'd0,   4'h1, 52'd2, 8'd0, 1'b0, 3'd0, 10'd0, 100);
        vecs[5] = mk(1'b0, 10'd20,  10'd0,   4'h0, 52'd0, 8'd0, 1'b1, 3'd2, 10'd255, 20);
        vecs[6] = mk(1'b0, 10'd40,  10'd0,   4'h0, 52'd0, 8'd0, 1'b1, 3'd2, 10'd255, 160);
        vecs[7] = mk(1'b0, 10'd100, 10'd0,   4'h0, 52'd0, 8'd0, 1'b1, 3'd2, 10'd255, 255);
        vecs[8] = mk(1'b0, 10'd0,   10'd100, 4'h0, 52'd0, 8'd0, 1'b1, 3'd2, 10'd255, 1024 + 255);

        repeat (3) @(negedge clk);
        check("reset ram_addr", int'(ram_addr), 0);
        check("reset ram_we", int'(ram_we), 0);
        check("reset ram_wdata", int'(ram_wdata), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_sample", int'(out_sample), 0);
        check("reset busy", int'(busy), 0);
        check("reset overrun", int'(overrun), 0);
        reset = 1'b0;
        ref_ptr = 0;

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].rst) do_reset();
            ref_process(int'(vecs[i].si), int'(vecs[i].off), vecs[i].en, vecs[i].dl,
                        vecs[i].sh, vecs[i].de, int'(vecs[i].ds), int'(vecs[i].sat));
            run_sample(vecs[i].si, vecs[i].off, vecs[i].en, vecs[i].dl, vecs[i].sh,
                       vecs[i].de, vecs[i].ds, vecs[i].sat);
            check($sformatf("vec%0d table out", i), g_out, vecs[i].exp_out);
            compare_all($sformatf("vec%0d", i));
        end

        // Read address wraps below zero into a preloaded location
        do_reset();
        @(negedge clk);
        pre_addr = 13'(DEPTH - 1); pre_data = 11'd50; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
        ref_mem[DEPTH - 1] = 11'd50;
        apply("wrap", 10'd10, 10'd0, 4'h1, 52'd1, 8'd0, 1'b0, 3'd0, 10'd0);
        check("wrap out_sample", g_out, 60);
        check("wrap read addr", rd_log[2], DEPTH - 1);

        // Back-to-back strobes: second dropped, overrun sticky until reset
        do_reset();
        ref_process(600, 100, 4'h0, 52'd0, 8'd0, 1'b0, 0, 0);
        @(negedge clk);
        sample_in = 10'd600; offset = 10'd100; tap_en = 4'h0; drive_en = 1'b0;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_in = 10'd999;
        @(negedge clk);
        sample_valid = 1'b0;
        ovc = 0; g_out = -1;
        repeat (20) begin
            if (out_valid) begin
                ovc++; g_out = int'(out_sample);
            end
            @(negedge clk);
        end
        check("overrun out_valid count", ovc, 1);
        check("overrun out_sample", g_out, e_out);
        check("overrun set", int'(overrun), 1);
        apply("after overrun", 10'd300, 10'd0, 4'h1, 52'd1, 8'd1, 1'b0, 3'd0, 10'd0);
        check("overrun still set", int'(overrun), 1);
        do_reset();
        check("overrun cleared", int'(overrun), 0);

        // Reset while reading taps aborts the sample
        dl_abort = {13'd4, 13'd3, 13'd2, 13'd1};
        ref_process(300, 0, 4'hF, dl_abort, 8'd0, 1'b0, 0, 0);
        @(negedge clk);
        sample_in = 10'd300; offset = 10'd0; tap_en = 4'hF; tap_delay = dl_abort;
        tap_shift = 8'd0; drive_en = 1'b0; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("abort write cycle", int'(ram_we), 1);
        @(negedge clk);
        check("abort busy in read", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort busy", int'(busy), 0);
        check("abort out_valid", int'(out_valid), 0);
        check("abort ram_we", int'(ram_we), 0);
        reset = 1'b0;
        ref_ptr = 0;
        ov_seen = 0; we_seen = 0;
        repeat (10) begin
            @(negedge clk);
            ov_seen += int'(out_valid);
            we_seen += int'(ram_we);
        end
        check("abort no out_valid", ov_seen, 0);
        check("abort no ram_we", we_seen, 0);

        // Randomized samples against the reference model
        for (int n = 0; n < 250; n++) begin
            logic [3:0] en;
            logic [7:0] sh;
            for (int t = 0; t < NUM_TAPS; t++)
                dl[t*ADDR_W +: ADDR_W] = ($urandom_range(0, 7) == 0) ?
                                         13'($urandom) : 13'($urandom_range(0, 20));
            en = 4'($urandom);
            sh = 8'($urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            apply($sformatf("rand%0d", n), 10'($urandom), 10'($urandom), en, dl, sh,
                  1'($urandom), 3'($urandom), 10'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
